// File: rtl/sparc_ifu_thrsched.sv
// Fetch-thread scheduler for the 4-thread IFU: per-thread run-state FSMs,
// least-recently-granted arbitration with a run quantum, registered one-hot select.
module sparc_ifu_thrsched #(
  parameter int QUANTUM = 8
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_se,
  input  logic       i_si,
  output logic       o_so,
  input  logic [3:0] i_thr_start,
  input  logic [3:0] i_thr_stop,
  input  logic [3:0] i_miss,
  input  logic [3:0] i_fill_early,
  input  logic [3:0] i_fill_cancel,
  input  logic [3:0] i_fill_done,
  input  logic       i_sw_req,
  input  logic       i_stall,
  output logic [3:0] o_thr_sel,
  output logic       o_thr_sel_spec,
  output logic [7:0] o_thr_state
);

  localparam logic [1:0] ST_DEAD = 2'b00;
  localparam logic [1:0] ST_RDY  = 2'b01;
  localparam logic [1:0] ST_WAIT = 2'b10;
  localparam logic [1:0] ST_SPEC = 2'b11;
  localparam logic [3:0] QMAX    = 4'(QUANTUM - 1);
  localparam int         CHAIN   = 25;

  logic [7:0] r_state;
  logic [3:0] r_sel;
  logic       r_sel_spec;
  logic [3:0] r_qcnt;
  // Four 2-bit thread ids; slot 0 (bits 1:0) is MRU, slot 3 is LRU.
  logic [7:0] r_lru;

  logic [7:0] w_state_nxt;
  logic [3:0] w_rdy_vec;
  logic [3:0] w_spec_vec;
  logic [3:0] w_cand;
  logic [1:0] w_sel_state;
  logic       w_sel_elig;
  logic       w_other_rdy;
  logic       w_sw;
  logic       w_pick_valid;
  logic       w_pick_spec;
  logic [1:0] w_pick_slot;
  logic [1:0] w_pick_thr;
  logic [7:0] w_lru_nxt;
  logic [3:0] w_sel_nxt;
  logic       w_spec_nxt;
  logic [3:0] w_qcnt_nxt;
  logic [CHAIN-1:0] w_chain_cur;
  logic [CHAIN-1:0] w_chain_func;
  logic [CHAIN-1:0] w_chain_nxt;

  always_comb begin
    w_state_nxt = r_state;
    for (int t = 0; t < 4; t++) begin
      if (i_thr_stop[t]) begin
        w_state_nxt[2*t +: 2] = ST_DEAD;
      end else begin
        case (r_state[2*t +: 2])
          ST_DEAD: if (i_thr_start[t]) w_state_nxt[2*t +: 2] = ST_RDY;
          ST_RDY:  if (i_miss[t])      w_state_nxt[2*t +: 2] = ST_WAIT;
          ST_WAIT: begin
            if (i_fill_done[t])       w_state_nxt[2*t +: 2] = ST_RDY;
            else if (i_fill_early[t]) w_state_nxt[2*t +: 2] = ST_SPEC;
          end
          default: begin
            if (i_fill_done[t])        w_state_nxt[2*t +: 2] = ST_RDY;
            else if (i_fill_cancel[t]) w_state_nxt[2*t +: 2] = ST_WAIT;
          end
        endcase
      end
    end
  end

  always_comb begin
    w_rdy_vec   = 4'b0000;
    w_spec_vec  = 4'b0000;
    w_sel_state = ST_DEAD;
    for (int t = 0; t < 4; t++) begin
      w_rdy_vec[t]  = (r_state[2*t +: 2] == ST_RDY);
      w_spec_vec[t] = (r_state[2*t +: 2] == ST_SPEC);
      if (r_sel[t]) w_sel_state = r_state[2*t +: 2];
    end
  end

  assign w_sel_elig  = (r_sel != 4'b0000) &&
                       (r_sel_spec ? (w_sel_state == ST_SPEC || w_sel_state == ST_RDY)
                                   : (w_sel_state == ST_RDY));
  assign w_other_rdy = |(w_rdy_vec & ~r_sel);
  assign w_sw        = ~i_stall & ((r_sel == 4'b0000) | ~w_sel_elig | i_sw_req |
                                   ((r_qcnt == QMAX) & w_other_rdy));

  // Walk MRU to LRU so the last candidate hit is the least recently granted.
  always_comb begin
    w_cand       = (w_rdy_vec != 4'b0000) ? w_rdy_vec : w_spec_vec;
    w_pick_spec  = (w_rdy_vec == 4'b0000) && (w_spec_vec != 4'b0000);
    w_pick_valid = 1'b0;
    w_pick_slot  = 2'd0;
    for (int s = 0; s < 4; s++) begin
      if (w_cand[r_lru[2*s +: 2]]) begin
        w_pick_valid = 1'b1;
        w_pick_slot  = 2'(s);
      end
    end
  end

  assign w_pick_thr = r_lru[2*w_pick_slot +: 2];

  always_comb begin
    w_lru_nxt = r_lru;
    if (w_sw && w_pick_valid) begin
      for (int s = 1; s < 4; s++) begin
        if (s <= int'(w_pick_slot)) w_lru_nxt[2*s +: 2] = r_lru[2*(s-1) +: 2];
      end
      w_lru_nxt[1:0] = w_pick_thr;
    end
  end

  always_comb begin
    w_sel_nxt  = r_sel;
    w_spec_nxt = r_sel_spec;
    w_qcnt_nxt = r_qcnt;
    if (!i_stall) begin
      if (w_sw) begin
        w_sel_nxt  = w_pick_valid ? (4'b0001 << w_pick_thr) : 4'b0000;
        w_spec_nxt = w_pick_valid & w_pick_spec;
      end else if (r_sel_spec && w_sel_state == ST_RDY) begin
        w_spec_nxt = 1'b0;
      end
      if (w_sel_nxt == 4'b0000 || w_sel_nxt != r_sel) w_qcnt_nxt = 4'd0;
      else if (r_qcnt != QMAX)                        w_qcnt_nxt = r_qcnt + 4'd1;
    end
  end

  // Scan shifts every flop as one chain; functional update otherwise.
  assign w_chain_cur  = {r_state, r_sel, r_sel_spec, r_qcnt, r_lru};
  assign w_chain_func = {w_state_nxt, w_sel_nxt, w_spec_nxt, w_qcnt_nxt, w_lru_nxt};
  assign w_chain_nxt  = i_se ? {w_chain_cur[CHAIN-2:0], i_si} : w_chain_func;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      {r_state, r_sel, r_sel_spec, r_qcnt, r_lru} <=
        {8'h00, 4'h0, 1'b0, 4'h0, 8'b11_10_01_00};
    end else begin
      {r_state, r_sel, r_sel_spec, r_qcnt, r_lru} <= w_chain_nxt;
    end
  end

  assign o_so           = w_chain_cur[CHAIN-1];
  assign o_thr_sel      = r_sel;
  assign o_thr_sel_spec = r_sel_spec;
  assign o_thr_state    = r_state;

endmodule

// File: tb/tb_sparc_ifu_thrsched.sv
// Scoreboard bench for the fetch-thread scheduler: a behavioural model queues the
// expected outputs for each driven cycle, which are popped and compared after the edge.
module tb_sparc_ifu_thrsched;

  localparam int Q         = 8;
  localparam int CHAIN_LEN = 25;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       se = 1'b0;
  logic       si = 1'b0;
  logic       so;
  logic [3:0] thrStart = '0;
  logic [3:0] thrStop = '0;
  logic [3:0] miss = '0;
  logic [3:0] fillEarly = '0;
  logic [3:0] fillCancel = '0;
  logic [3:0] fillDone = '0;
  logic       swReq = 1'b0;
  logic       stall = 1'b0;
  logic [3:0] thrSel;
  logic       thrSelSpec;
  logic [7:0] thrState;

  always #5 clk = ~clk;

  sparc_ifu_thrsched #(.QUANTUM(Q)) dut (
    .i_clk(clk), .i_reset(reset), .i_se(se), .i_si(si), .o_so(so),
    .i_thr_start(thrStart), .i_thr_stop(thrStop), .i_miss(miss),
    .i_fill_early(fillEarly), .i_fill_cancel(fillCancel), .i_fill_done(fillDone),
    .i_sw_req(swReq), .i_stall(stall),
    .o_thr_sel(thrSel), .o_thr_sel_spec(thrSelSpec), .o_thr_state(thrState)
  );

  typedef struct packed {
    logic [3:0] sel;
    logic       spec;
    logic [7:0] st;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  // Model: states 0 dead, 1 rdy, 2 wait, 3 spec; mLru front is MRU.
  int mSt[4];
  int mSel;
  bit mSpec;
  int mQ;
  int mLru[$];

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic modelReset();
    for (int t = 0; t < 4; t++) mSt[t] = 0;
    mSel  = -1;
    mSpec = 0;
    mQ    = 0;
    mLru  = '{0, 1, 2, 3};
  endtask

  task automatic applyStimulus(input logic rst, input logic [3:0] st, input logic [3:0] sp,
                               input logic [3:0] ms, input logic [3:0] fe, input logic [3:0] fc,
                               input logic [3:0] fd, input logic sr, input logic stl);
    int   nSt[4];
    int   nSel;
    bit   nSpec;
    int   nQ;
    int   pick;
    int   pickIdx;
    bit   pickSpec;
    bit   elig;
    bit   othersRdy;
    bit   sw;
    exp_t e;
    exp_t got;
    reset = rst; se = 1'b0; thrStart = st; thrStop = sp; miss = ms;
    fillEarly = fe; fillCancel = fc; fillDone = fd; swReq = sr; stall = stl;
    if (rst) begin
      modelReset();
    end else begin
      for (int t = 0; t < 4; t++) begin
        nSt[t] = mSt[t];
        if (sp[t]) nSt[t] = 0;
        else if (mSt[t] == 0 && st[t]) nSt[t] = 1;
        else if (mSt[t] == 1 && ms[t]) nSt[t] = 2;
        else if ((mSt[t] == 2 || mSt[t] == 3) && fd[t]) nSt[t] = 1;
        else if (mSt[t] == 2 && fe[t]) nSt[t] = 3;
        else if (mSt[t] == 3 && fc[t]) nSt[t] = 2;
      end
      elig = 0;
      if (mSel >= 0) elig = mSpec ? (mSt[mSel] == 1 || mSt[mSel] == 3) : (mSt[mSel] == 1);
      othersRdy = 0;
      for (int t = 0; t < 4; t++) if (t != mSel && mSt[t] == 1) othersRdy = 1;
      sw = !stl && (mSel < 0 || !elig || sr || (mQ == Q - 1 && othersRdy));
      nSel = mSel; nSpec = mSpec; nQ = mQ;
      if (sw) begin
        pick = -1; pickIdx = -1; pickSpec = 0;
        for (int i = 3; i >= 0; i--)
          if (pick < 0 && mSt[mLru[i]] == 1) begin pick = mLru[i]; pickIdx = i; end
        for (int i = 3; i >= 0; i--)
          if (pick < 0 && mSt[mLru[i]] == 3) begin pick = mLru[i]; pickIdx = i; pickSpec = 1; end
        nSel = pick;
        nSpec = pickSpec;
        if (pick >= 0) begin
          mLru.delete(pickIdx);
          mLru.push_front(pick);
        end
      end else if (!stl && mSel >= 0 && mSpec && mSt[mSel] == 1) begin
        nSpec = 0;
      end
      if (!stl) begin
        if (nSel < 0 || nSel != mSel) nQ = 0;
        else if (mQ < Q - 1) nQ = mQ + 1;
      end
      mSt = nSt; mSel = nSel; mSpec = nSpec; mQ = nQ;
    end
    e.sel  = (mSel < 0) ? 4'b0000 : (4'b0001 << mSel);
    e.spec = mSpec;
    for (int t = 0; t < 4; t++) e.st[2*t +: 2] = 2'(mSt[t]);
    expQ.push_back(e);
    @(posedge clk);
    #1;
    if (expQ.size() == 0) begin
      checks++; errors++;
      $display("[TB] FAIL scoreboard: got empty queue expected an entry");
    end else begin
      got = expQ.pop_front();
      checkOutput("sb_sel",   {4'b0, thrSel},     {4'b0, got.sel});
      checkOutput("sb_spec",  {7'b0, thrSelSpec}, {7'b0, got.spec});
      checkOutput("sb_state", thrState,           got.st);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
  endtask

  function automatic logic [3:0] rnd4(input int p16);
    logic [3:0] v;
    for (int b = 0; b < 4; b++) v[b] = ($urandom_range(0, 15) < p16);
    return v;
  endfunction

  initial begin
    logic [49:0] pat;
    modelReset();
    applyStimulus(1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    checkOutput("reset_sel", {4'b0, thrSel}, 8'h00);
    checkOutput("reset_state", thrState, 8'h00);

    // t0 and t2 start; t2 is LRU-lower, then the two alternate per quantum.
    applyStimulus(1'b0, 4'b0101, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    idle(1);
    checkOutput("first_grant", {4'b0, thrSel}, 8'h04);
    idle(7);
    idle(1);
    checkOutput("quantum_switch_t0", {4'b0, thrSel}, 8'h01);
    idle(7);
    idle(1);
    checkOutput("quantum_switch_t2", {4'b0, thrSel}, 8'h04);

    applyStimulus(1'b0, 4'h0, 4'h0, 4'b0100, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    checkOutput("miss_state", thrState, 8'h21);
    idle(1);
    checkOutput("miss_switch", {4'b0, thrSel}, 8'h01);
    applyStimulus(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'b0100, 1'b0, 1'b0);
    idle(6);
    idle(1);
    checkOutput("refill_regrant", {4'b0, thrSel}, 8'h04);

    applyStimulus(1'b0, 4'h0, 4'b1111, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    idle(1);
    checkOutput("all_dead_sel", {4'b0, thrSel}, 8'h00);
    applyStimulus(1'b0, 4'b1111, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    idle(2);
    applyStimulus(1'b0, 4'h0, 4'h0, 4'b1111, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'h0, 4'h0, 4'h0, 4'b1000, 4'h0, 4'h0, 1'b0, 1'b0);
    checkOutput("all_wait_sel", {4'b0, thrSel}, 8'h00);
    idle(1);
    checkOutput("spec_grant_sel", {4'b0, thrSel}, 8'h08);
    checkOutput("spec_grant_flag", {7'b0, thrSelSpec}, 8'h01);
    applyStimulus(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'b1000, 4'h0, 1'b0, 1'b0);
    idle(1);
    checkOutput("cancel_drop", {4'b0, thrSel}, 8'h00);
    applyStimulus(1'b0, 4'h0, 4'h0, 4'h0, 4'b1000, 4'h0, 4'h0, 1'b0, 1'b0);
    idle(1);
    applyStimulus(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'b1000, 1'b0, 1'b0);
    idle(1);
    checkOutput("promote_sel", {4'b0, thrSel}, 8'h08);
    checkOutput("promote_flag", {7'b0, thrSelSpec}, 8'h00);

    // Stall with a pending switch request; FSMs still react to misses meanwhile.
    applyStimulus(1'b0, 4'b0111, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    idle(5);
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b0, 4'h0, 4'h0, (i == 2) ? 4'b0001 : 4'b0000, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1);
    idle(3);

    applyStimulus(1'b0, 4'b0010, 4'b0010, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    checkOutput("stop_wins", {6'b0, thrState[3:2]}, 8'h00);
    idle(3);
    applyStimulus(1'b1, 4'b1111, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
    checkOutput("midrun_reset_sel", {4'b0, thrSel}, 8'h00);
    checkOutput("midrun_reset_state", thrState, 8'h00);
    applyStimulus(1'b0, 4'b1111, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    idle(1);
    checkOutput("lru_after_reset", {4'b0, thrSel}, 8'h08);

    for (int c = 0; c < 600; c++)
      applyStimulus(($urandom_range(0, 99) == 0), rnd4(4), rnd4(1), rnd4(2), rnd4(3), rnd4(2),
                    rnd4(3), ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0));

    // Scan: a pattern shifted in must emerge at so after the chain length.
    pat = 50'({$urandom(), $urandom()});
    reset = 1'b0; stall = 1'b0; swReq = 1'b0;
    se = 1'b1;
    for (int k = 0; k < 50; k++) begin
      si = pat[k];
      @(posedge clk);
      #1;
      if (k >= CHAIN_LEN - 1) checkOutput("scan_out", {7'b0, so}, {7'b0, pat[k - CHAIN_LEN + 1]});
    end
    se = 1'b0;
    applyStimulus(1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
